mips_fetch_unit: RTL and testbench
==================================

Name: mips_fetch_unit

Overview:
- Decoupled instruction-fetch front end for the next-generation MIPS core.
- Replaces the combinational PC/next-PC logic of the single-cycle core with a parametrised fetch engine that has:
  - a synchronous 1-cycle-latency instruction memory interface,
  - a DEPTH-entry prefetch FIFO with a valid/ready handshake toward decode,
  - zero-bubble predecode of J/JAL,
  - a redirect port for branches and register jumps resolved downstream.

Parameters:
- XLEN, 32, PC and instruction width (instruction fields follow standard MIPS encoding; XLEN >= 32).
- DEPTH, 4, prefetch FIFO entries; power of two, >= 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- PREDECODE_JUMP, 1, 1 = fetch unit redirects itself on J/JAL; 0 = sequential fetch only.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request this cycle.
- imem_addr  output  XLEN  fetch address, bits[1:0] always 00.
- imem_rdata  input  XLEN  instruction, valid exactly one cycle after imem_req.
- redirect_valid  input  1  downstream redirect (taken branch, JR).
- redirect_target  input  XLEN  redirect address; bits[1:0] ignored.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  decode accepts head.
- out_instr  output  XLEN  head instruction.
- out_pc  output  XLEN  head instruction address.
- out_pc_plus4  output  XLEN  out_pc + 4.
- out_predicted  output  1  head is J/JAL already followed by fetch.
- fifo_count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async, immediate):
  - pc = RESET_PC, FIFO empty, in-flight flag cleared.
  - imem_req = 0, out_valid = 0, out_predicted = 0, fifo_count = 0.
  - out_instr, out_pc and out_pc_plus4 = 0.
  - First imem_req is issued in the first cycle after rst deasserts.
- Issue rule: imem_req = !redirect_valid && (fifo_count + inflight < DEPTH).
  - inflight = 1 if a request was issued in the previous cycle and has not been squashed.
  - Guarantees a response never finds the FIFO full. There is no overflow path.
- Response: in the cycle after an issued request, imem_rdata is captured into the FIFO tail together with its PC, unless squashed.
  - A captured entry becomes visible at the head no earlier than the following cycle. There is no bypass.
- Address select, in priority order:
  - (1) redirect_valid: no request this cycle; pc <= {redirect_target[XLEN-1:2], 2'b00}.
  - (2) PREDECODE_JUMP = 1 and an unsquashed response has opcode 6'b000010 or 6'b000011:
    - imem_addr = {resp_pc_plus4[XLEN-1:28], instr[25:0], 2'b00} in the same cycle;
    - pc <= that target + 4;
    - the entry is enqueued with predicted = 1.
  - (3) Otherwise imem_addr = pc and pc <= pc + 4 when imem_req is issued.
  - Arithmetic is modulo 2^XLEN; the PC wraps from 0xFFFF_FFFC to 0.
- Redirect:
  - At the next edge the FIFO is flushed, and any response arriving in the redirect cycle is discarded (squashed).
  - A head handshake in the redirect cycle still completes from the consumer's view.
  - Timing:
    - Redirect in cycle N.
    - Request to target in N+1.
    - Response captured at the end of N+2.
    - out_valid in N+3.
  - Back-to-back redirects: the last one wins. Each redirect cycle suppresses the request.
- Handshake:
  - Pop occurs on out_valid && out_ready.
  - out_* are held stable while out_valid && !out_ready.
  - Simultaneous push and pop keeps fifo_count unchanged. This is allowed at full and at empty+1.
- Sequencing: J/JAL entries are delivered in program order; the next FIFO entry after a predicted jump is the jump target.
  - Downstream must not redirect on an out_predicted instruction. If it does, the redirect is still honoured, and the result is harmless apart from the refetch.
- PREDECODE_JUMP = 0: out_predicted is tied to 0, and fetch after J/JAL stays sequential until redirected.
- Reset mid-operation: the FIFO and the in-flight request are abandoned. A late imem_rdata is ignored.

Test Plan:
- Reset release, RESET_PC=0x0, out_ready=1, memory returns NOPs -> imem_addr 0x0,0x4,0x8,... on consecutive cycles; out_pc 0x0 valid on the third cycle after release.
- out_ready=0 with DEPTH=4 -> exactly 4 requests issued (0x0..0xC), then imem_req=0 and fifo_count=4 held; raise out_ready -> entries pop in order 0x0,0x4,0x8,0xC and fetch resumes at 0x10.
- Word 0x8 = J 0x100 (0x08000040) -> request following the 0x8 response goes to 0x100 in the same cycle; the out sequence is 0x8 (out_predicted=1), then 0x100. 0xC never appears.
- redirect_valid with target 0x2003 in a cycle where a response is arriving -> that response is dropped, FIFO is empty next cycle, next request goes to 0x2000, and out_pc=0x2000 becomes valid 3 cycles after the redirect.
- redirect_valid in the same cycle as a J response and an out handshake -> the redirect wins, no request to the jump target is issued, and the next fetch is the redirect target.
- rst asserted while a request is in flight and FIFO holds 2 -> all outputs are 0 immediately, and after release fetch restarts at RESET_PC with no stale entry.

Source files
------------

// File: rtl/mips_fetch_unit.sv
// Purpose: decoupled MIPS instruction fetch with prefetch FIFO, J/JAL predecode and redirect.
// Latency: request -> imem response next cycle -> FIFO head visible the cycle after (3 cycles from redirect/reset to out_valid).
// Backpressure: out_ready low fills the FIFO; requests stop once occupancy plus the in-flight slot reaches DEPTH.
module mips_fetch_unit #(
    parameter int              XLEN           = 32,
    parameter int              DEPTH          = 4,
    parameter logic [XLEN-1:0] RESET_PC       = {XLEN{1'b0}},
    parameter int              PREDECODE_JUMP = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_req,
    output logic [XLEN-1:0]            imem_addr,
    input  logic [XLEN-1:0]            imem_rdata,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_target,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_instr,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_pc_plus4,
    output logic                       out_predicted,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int              AW       = $clog2(DEPTH);
    localparam int              CW       = AW + 1;
    localparam logic [CW:0]     DEPTH_W  = (CW+1)'(DEPTH);
    localparam logic [XLEN-1:0] WORD_MSK = ~(XLEN'(3));
    localparam logic [XLEN-1:0] LOW28    = XLEN'(32'h0FFF_FFFF);
    localparam logic [XLEN-1:0] FOUR     = XLEN'(4);

    // fetch state
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] resp_pc;
    logic            inflight;

    // prefetch FIFO storage and pointers
    logic [XLEN-1:0] fifo_instr [DEPTH];
    logic [XLEN-1:0] fifo_pc    [DEPTH];
    logic [DEPTH-1:0] fifo_pred;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    // datapath helpers
    logic            resp_live;
    logic            resp_is_j;
    logic [XLEN-1:0] resp_pc_plus4;
    logic [XLEN-1:0] jump_target;
    logic [XLEN-1:0] redirect_pc;
    logic [CW:0]     occupancy;
    logic            issue;
    logic            push;
    logic            pop;

    // response qualification, jump predecode and issue decision
    always_comb begin
        resp_live     = inflight && !redirect_valid;
        resp_is_j     = (PREDECODE_JUMP != 0) && resp_live &&
                        ((imem_rdata[31:26] == 6'b000010) || (imem_rdata[31:26] == 6'b000011));
        resp_pc_plus4 = resp_pc + FOUR;
        // region bits come from the delay-slot PC, low bits from the 26-bit index
        jump_target   = (resp_pc_plus4 & ~LOW28) | (XLEN'(imem_rdata[25:0]) << 2);
        redirect_pc   = redirect_target & WORD_MSK;
        occupancy     = {1'b0, count} + {{CW{1'b0}}, inflight};
        // counting the in-flight slot means a response always has room
        issue         = !rst && !redirect_valid && (occupancy < DEPTH_W);
        push          = resp_live;
        pop           = out_valid && out_ready;
    end

    assign imem_req  = issue;
    assign imem_addr = resp_is_j ? jump_target : pc;

    // PC, in-flight flag and the PC of the outstanding request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC & WORD_MSK;
            resp_pc  <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                resp_pc <= imem_addr;
            end
            if (redirect_valid) begin
                pc <= redirect_pc;
            end else if (resp_is_j) begin
                // if the target could not be requested now, fetch it next time
                pc <= issue ? (jump_target + FOUR) : jump_target;
            end else if (issue) begin
                pc <= pc + FOUR;
            end
        end
    end

    // FIFO pointers and occupancy; a redirect flushes everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO payload write; contents are qualified by count so need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]    <= resp_pc;
            fifo_pred[wr_ptr]  <= resp_is_j;
        end
    end

    assign out_valid     = (count != '0);
    assign fifo_count    = count;
    assign out_instr     = out_valid ? fifo_instr[rd_ptr] : '0;
    assign out_pc        = out_valid ? fifo_pc[rd_ptr] : '0;
    assign out_pc_plus4  = out_valid ? (fifo_pc[rd_ptr] + FOUR) : '0;
    assign out_predicted = out_valid && fifo_pred[rd_ptr];

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: reset, streaming, backpressure, J predecode,
// redirect squash, redirect vs jump priority, mid-operation reset and PC wrap.
module tb_mips_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'hFFFF_FFFF;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        out_predicted;
    logic [2:0]  fifo_count;

    int vectors = 0;
    int errs    = 0;
    bit jump_en = 1'b0;

    mips_fetch_unit #(
        .XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .PREDECODE_JUMP(1)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_pc_plus4(out_pc_plus4),
        .out_predicted(out_predicted), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // memory image: low 16 address bits as an opcode-0 word, optional J 0x100 at 0x8
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (jump_en && a == 32'h8) return 32'h0800_0040;
        return {16'h0, a[15:0]};
    endfunction

    // synchronous 1-cycle memory
    always @(posedge clk) begin
        imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hFFFF_FFFF;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // hold reset two edges, release mid-cycle; returns in cycle C1 after settle
    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        #2;
        chk("rst_req",   {31'h0, imem_req},  32'h0);
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_count", {29'h0, fifo_count}, 32'h0);
        chk("rst_pc",    out_pc, 32'h0);

        // ---------------- streaming, out_ready=1 ----------------
        out_ready = 1'b1; jump_en = 1'b0;
        do_reset();
        chk("s1_req",  {31'h0, imem_req}, 32'h1);
        chk("s1_addr", imem_addr, 32'h0);
        cyc(); #1;
        chk("s2_addr",  imem_addr, 32'h4);
        chk("s2_valid", {31'h0, out_valid}, 32'h0);
        cyc(); #1;
        chk("s3_addr",  imem_addr, 32'h8);
        chk("s3_valid", {31'h0, out_valid}, 32'h1);
        chk("s3_pc",    out_pc, 32'h0);
        chk("s3_pc4",   out_pc_plus4, 32'h4);
        chk("s3_instr", out_instr, 32'h0);
        cyc(); #1;
        chk("s4_pc",    out_pc, 32'h4);
        chk("s4_instr", out_instr, 32'h4);
        chk("s4_addr",  imem_addr, 32'hC);
        chk("s4_count", {29'h0, fifo_count}, 32'h1);

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        do_reset();
        chk("b1_addr", imem_addr, 32'h0);
        cyc(); #1; chk("b2_addr", imem_addr, 32'h4);
        cyc(); #1; chk("b3_addr", imem_addr, 32'h8);
        cyc(); #1; chk("b4_addr", imem_addr, 32'hC);
        chk("b4_req", {31'h0, imem_req}, 32'h1);
        cyc(); #1;
        chk("b5_req",   {31'h0, imem_req}, 32'h0);
        chk("b5_count", {29'h0, fifo_count}, 32'h3);
        cyc(); #1;
        chk("b6_req",   {31'h0, imem_req}, 32'h0);
        chk("b6_count", {29'h0, fifo_count}, 32'h4);
        chk("b6_pc",    out_pc, 32'h0);
        cyc(); out_ready = 1'b1; #1;
        chk("b7_req",   {31'h0, imem_req}, 32'h0);
        chk("b7_count", {29'h0, fifo_count}, 32'h4);
        chk("b7_pc",    out_pc, 32'h0);
        cyc(); #1;
        chk("b8_pc",    out_pc, 32'h4);
        chk("b8_addr",  imem_addr, 32'h10);
        chk("b8_req",   {31'h0, imem_req}, 32'h1);
        chk("b8_count", {29'h0, fifo_count}, 32'h3);
        cyc(); #1; chk("b9_pc",  out_pc, 32'h8);
        cyc(); #1; chk("b10_pc", out_pc, 32'hC);
        cyc(); #1; chk("b11_pc", out_pc, 32'h10);

        // ---------------- J predecode ----------------
        out_ready = 1'b1; jump_en = 1'b1;
        do_reset();
        cyc(); #1;
        cyc(); #1;
        chk("j3_addr", imem_addr, 32'h8);
        cyc(); #1;
        chk("j4_addr", imem_addr, 32'h100);
        chk("j4_req",  {31'h0, imem_req}, 32'h1);
        chk("j4_pc",   out_pc, 32'h4);
        cyc(); #1;
        chk("j5_addr",  imem_addr, 32'h104);
        chk("j5_pc",    out_pc, 32'h8);
        chk("j5_pred",  {31'h0, out_predicted}, 32'h1);
        chk("j5_instr", out_instr, 32'h0800_0040);
        cyc(); #1;
        chk("j6_pc",   out_pc, 32'h100);
        chk("j6_pred", {31'h0, out_predicted}, 32'h0);
        cyc(); #1;
        chk("j7_pc", out_pc, 32'h104);

        // ---------------- redirect squashes arriving response ----------------
        jump_en = 1'b0;
        do_reset();
        cyc(); redirect_valid = 1'b1; redirect_target = 32'h2003; #1;
        chk("r2_req", {31'h0, imem_req}, 32'h0);
        cyc(); redirect_valid = 1'b0; #1;
        chk("r3_count", {29'h0, fifo_count}, 32'h0);
        chk("r3_valid", {31'h0, out_valid}, 32'h0);
        chk("r3_addr",  imem_addr, 32'h2000);
        chk("r3_req",   {31'h0, imem_req}, 32'h1);
        cyc(); #1;
        chk("r4_valid", {31'h0, out_valid}, 32'h0);
        cyc(); #1;
        chk("r5_valid", {31'h0, out_valid}, 32'h1);
        chk("r5_pc",    out_pc, 32'h2000);

        // ---------------- redirect beats J response and handshake ----------------
        jump_en = 1'b1;
        do_reset();
        cyc(); #1;
        cyc(); #1;
        cyc(); redirect_valid = 1'b1; redirect_target = 32'h3000; #1;
        chk("p4_req", {31'h0, imem_req}, 32'h0);
        chk("p4_pc",  out_pc, 32'h4);
        cyc(); redirect_valid = 1'b0; #1;
        chk("p5_addr",  imem_addr, 32'h3000);
        chk("p5_req",   {31'h0, imem_req}, 32'h1);
        chk("p5_valid", {31'h0, out_valid}, 32'h0);
        cyc(); #1;
        chk("p6_addr", imem_addr, 32'h3004);
        cyc(); #1;
        chk("p7_pc",   out_pc, 32'h3000);
        chk("p7_pred", {31'h0, out_predicted}, 32'h0);

        // ---------------- reset mid-operation ----------------
        jump_en = 1'b0; out_ready = 1'b0;
        do_reset();
        cyc(); #1;
        cyc(); #1;
        cyc(); #1;
        chk("m4_count", {29'h0, fifo_count}, 32'h2);
        rst = 1'b1; #1;
        chk("m_req",   {31'h0, imem_req}, 32'h0);
        chk("m_addr",  imem_addr, 32'h0);
        chk("m_valid", {31'h0, out_valid}, 32'h0);
        chk("m_count", {29'h0, fifo_count}, 32'h0);
        chk("m_instr", out_instr, 32'h0);
        chk("m_pc",    out_pc, 32'h0);
        chk("m_pc4",   out_pc_plus4, 32'h0);
        chk("m_pred",  {31'h0, out_predicted}, 32'h0);
        out_ready = 1'b1;
        do_reset();
        chk("m1_addr", imem_addr, 32'h0);
        cyc(); #1;
        chk("m2_valid", {31'h0, out_valid}, 32'h0);
        cyc(); #1;
        chk("m3_pc", out_pc, 32'h0);

        // ---------------- PC wrap via redirect ----------------
        cyc(); redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFF9; #1;
        chk("w0_req", {31'h0, imem_req}, 32'h0);
        cyc(); redirect_valid = 1'b0; #1;
        chk("w1_addr", imem_addr, 32'hFFFF_FFF8);
        cyc(); #1;
        chk("w2_addr", imem_addr, 32'hFFFF_FFFC);
        cyc(); #1;
        chk("w3_addr", imem_addr, 32'h0);
        chk("w3_pc",   out_pc, 32'hFFFF_FFF8);
        cyc(); #1;
        chk("w4_pc",  out_pc, 32'hFFFF_FFFC);
        chk("w4_pc4", out_pc_plus4, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
